output_neuron_p: RTL

OUTPUT_NEURON_P -- requirements
Module: output_neuron_p

---
 rtl/output_neuron_p.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/output_neuron_p.sv
// Output-layer leaky integrate-and-fire neuron with lateral inhibition
// handshake and an on-chip STDP-style weight update.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          one-cycle pulse; begins one time-unit evaluation (IDLE only)
//   spike_in[M]    input spike vector, latched with start
//   learn_en       weight update enable, latched with start
//   li_en          lateral-inhibition enable, latched with start
//   li_req         held high while waiting for the arbitration result
//   li_ack/li_won  arbitration strobe and result (li_won qualified by li_ack)
//   del_w_plus/minus  unsigned weight increment / decrement magnitudes
//   init_we/addr/data weight preload port, honoured in IDLE only
//   spike_out      fire flag, pulses together with valid
//   valid          one-cycle pulse when an evaluation completes
//   busy           high whenever the FSM is not IDLE
//   potential      registered signed membrane potential
//   state_dbg      current FSM state encoding
//
// Handshake: start is accepted only in the cycle it is seen in IDLE; li_ack
// is a single-cycle strobe that only has meaning while li_req is high, and
// valid/spike_out are single-cycle strobes issued from DONE.
module output_neuron_p #(
    parameter int M    = 784,
    parameter int W    = 24,
    parameter int AW   = 10,
    parameter int TH   = 15018,
    parameter int LEAK = 614,
    parameter int PRES = 0,
    parameter int PMIN = -2048000,
    parameter int WMAX = 6144,
    parameter int WMIN = -4915,
    parameter int REF  = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [M-1:0]        spike_in,
    input  logic                learn_en,
    input  logic                li_en,
    output logic                li_req,
    input  logic                li_ack,
    input  logic                li_won,
    input  logic [W-1:0]        del_w_plus,
    input  logic [W-1:0]        del_w_minus,
    input  logic                init_we,
    input  logic [AW-1:0]       init_addr,
    input  logic [W-1:0]        init_data,
    output logic                spike_out,
    output logic                valid,
    output logic                busy,
    output logic signed [W-1:0] potential,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        LEAKCMP = 3'd2,
        LI_WAIT = 3'd3,
        UPDATE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    // cnt must reach M+1 even when M == 2^AW
    localparam int CW = AW + 2;
    localparam int RW = $clog2(REF + 1) + 1;

    localparam logic signed [W:0]   P_MAX  = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]   P_MIN  = (W+1)'(PMIN);
    localparam logic signed [W:0]   LEAK_X = (W+1)'(LEAK);
    localparam logic signed [W-1:0] TH_W   = W'(TH);
    localparam logic signed [W-1:0] P_RES  = W'(PRES);
    localparam logic signed [W+1:0] WMAX_Y = (W+2)'(WMAX);
    localparam logic signed [W+1:0] WMIN_Y = (W+2)'(WMIN);
    localparam logic [RW-1:0]       REF_V  = RW'(REF);
    localparam logic [CW-1:0]       M_C    = CW'(M);
    localparam logic [CW-1:0]       M1_C   = CW'(M + 1);

    state_t state, state_n;

    logic [CW-1:0]        cnt;
    logic [RW-1:0]        ref_cnt;
    logic [M-1:0]         spk_q;     // latched spike vector, reused by UPDATE
    logic [M-1:0]         spk_sh;    // walking copy; bit 0 lines up with rd_data
    logic                 learn_q, li_q, fire_q;

    logic [W-1:0]         mem [0:M-1];
    logic signed [W-1:0]  rd_data;
    logic [AW-1:0]        rd_addr, rd_addr_q;
    logic                 rd_en;

    logic                 wb_vld;
    logic [AW-1:0]        wb_addr;
    logic [W-1:0]         wb_data;

    logic signed [W:0]    pot_x, w_x, acc_x, leak_x;
    logic signed [W-1:0]  acc_sat, leak_sat;
    logic signed [W+1:0]  w_y, d_p, d_m, w_t;
    logic [W-1:0]         w_upd;

    function automatic logic signed [W-1:0] sat_pot(input logic signed [W:0] x);
        if (x > P_MAX)      return P_MAX[W-1:0];
        else if (x < P_MIN) return P_MIN[W-1:0];
        else                return x[W-1:0];
    endfunction

    // Potential arithmetic in W+1 bits, saturated back into range
    always_comb begin
        pot_x    = {potential[W-1], potential};
        w_x      = {rd_data[W-1], rd_data};
        acc_x    = pot_x + w_x;
        leak_x   = pot_x - LEAK_X;
        acc_sat  = sat_pot(acc_x);
        leak_sat = sat_pot(leak_x);
    end

    // Weight update in W+2 bits so an unsigned W-bit delta cannot overflow
    always_comb begin
        w_y = {{2{rd_data[W-1]}}, rd_data};
        d_p = {2'b00, del_w_plus};
        d_m = {2'b00, del_w_minus};
        w_t = spk_sh[0] ? (w_y + d_p) : (w_y - d_m);
        if (w_t > WMAX_Y)      w_upd = WMAX_Y[W-1:0];
        else if (w_t < WMIN_Y) w_upd = WMIN_Y[W-1:0];
        else                   w_upd = w_t[W-1:0];
    end

    assign rd_addr = cnt[AW-1:0];
    assign rd_en   = ((state == ACCUM) || (state == UPDATE)) && (cnt < M_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (ref_cnt != '0) ? LEAKCMP : ACCUM;
            ACCUM:   if (cnt == M_C) state_n = LEAKCMP;
            LEAKCMP: begin
                if (ref_cnt != '0)       state_n = DONE;
                else if (leak_sat >= TH_W) begin
                    if (li_q)            state_n = LI_WAIT;
                    else if (learn_q)    state_n = UPDATE;
                    else                 state_n = DONE;
                end
                else                     state_n = DONE;
            end
            LI_WAIT: if (li_ack) state_n = (li_won && learn_q) ? UPDATE : DONE;
            UPDATE:  if (cnt == M1_C) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            potential <= P_RES;
            ref_cnt   <= '0;
            cnt       <= '0;
            spk_q     <= '0;
            spk_sh    <= '0;
            learn_q   <= 1'b0;
            li_q      <= 1'b0;
            fire_q    <= 1'b0;
            wb_vld    <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            wb_vld <= 1'b0;
            if (state_n != state)
                cnt <= '0;
            else if ((state == ACCUM) || (state == UPDATE))
                cnt <= cnt + 1'b1;

            case (state)
                IDLE: if (start) begin
                    spk_q   <= spike_in;
                    spk_sh  <= spike_in;
                    learn_q <= learn_en;
                    li_q    <= li_en;
                    fire_q  <= 1'b0;
                end
                // cnt==0 is the read-latency cycle; weight i arrives at cnt==i+1
                ACCUM: if (cnt != '0) begin
                    spk_sh <= spk_sh >> 1;
                    if (spk_sh[0]) potential <= acc_sat;
                end
                LEAKCMP: begin
                    potential <= leak_sat;
                    if (ref_cnt != '0)
                        ref_cnt <= ref_cnt - 1'b1;
                    else if ((leak_sat >= TH_W) && !li_q) begin
                        potential <= P_RES;
                        ref_cnt   <= REF_V;
                        fire_q    <= 1'b1;
                    end
                end
                LI_WAIT: if (li_ack) begin
                    potential <= P_RES;
                    if (li_won) begin
                        ref_cnt <= REF_V;
                        fire_q  <= 1'b1;
                    end
                end
                // read at cnt, modify at cnt+1, write back at cnt+2
                UPDATE: if ((cnt != '0) && (cnt <= M_C)) begin
                    spk_sh  <= spk_sh >> 1;
                    wb_vld  <= 1'b1;
                    wb_addr <= rd_addr_q;
                    wb_data <= w_upd;
                end
                default: ;
            endcase

            if ((state_n == UPDATE) && (state != UPDATE))
                spk_sh <= spk_q;
        end
    end

    // Weight RAM: contents deliberately survive rst
    always_ff @(posedge clk) begin
        if ((state == IDLE) && init_we) begin
            if (int'(init_addr) < M) mem[init_addr] <= init_data;
        end else if ((state == UPDATE) && wb_vld) begin
            mem[wb_addr] <= wb_data;
        end
        if (rd_en) begin
            rd_data   <= mem[rd_addr];
            rd_addr_q <= rd_addr;
        end
    end

    assign li_req    = (state == LI_WAIT);
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);
    assign spike_out = (state == DONE) && fire_q;
    assign state_dbg = state;

endmodule
